// File: rtl/nios_system_stream_pkg.sv
// Shared types for the on-chip RAM stream reader: FSM states, RAM geometry defaults
// and the beat record that travels through the output FIFO.
package nios_system_stream_pkg;

    localparam int DEF_MEM_WORDS = 31250;
    localparam int DEF_ADDR_W    = 15;
    localparam int DATA_W        = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

endpackage

// File: rtl/nios_system_stream_fifo.sv
// Synchronous FIFO holding stream beats between RAM capture and the sink.
// flush empties it in one cycle and takes priority over push/pop.
module nios_system_stream_fifo
    import nios_system_stream_pkg::*;
#(
    parameter int WIDTH = $bits(beat_t),
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage is deliberately not reset; only pointers and count need a defined value.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/nios_system_onchip_stream_reader.sv
// Avalon-MM read master that streams a block of on-chip RAM words out as one Avalon-ST packet.
// Optional running checksum of delivered words when STREAM_READER_CKSUM_EN is defined.
module nios_system_onchip_stream_reader
    import nios_system_stream_pkg::*;
#(
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
`ifdef STREAM_READER_CKSUM_EN
    ,output logic [DATA_W-1:0] cksum
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issued;
    logic [ADDR_W-1:0] issued_next;
    logic [ADDR_W-1:0] addr_inc;
    logic              cs_sop;
    logic              cs_eop;
    logic              inflight;
    logic              infl_sop;
    logic              infl_eop;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic              fifo_empty;
    logic              pop;
    logic              flush;
    logic              room;
    logic              can_issue;
    beat_t             push_beat;
    beat_t             head_beat;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign pop   = !fifo_empty && st_ready;
    assign flush = abort && (state == READ || state == DRAIN);

    // Occupancy after this edge: a read issued now lands in the FIFO two edges later,
    // so the FIFO words, the in-flight word and the issuing word must all fit.
    assign count_next  = fifo_count + CNT_W'(inflight) - CNT_W'(pop);
    assign room        = (OCC_W'(count_next) + OCC_W'(mem_chipselect)) < OCC_W'(FIFO_DEPTH);
    assign issued_next = issued + ADDR_W'(mem_chipselect);
    assign can_issue   = (issued_next < len_q) && room;
    assign addr_inc    = (mem_address == ADDR_W'(MEM_WORDS - 1)) ? '0 : mem_address + ADDR_W'(1);

    assign push_beat = '{data: mem_readdata, sop: infl_sop, eop: infl_eop};

    nios_system_stream_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (push_beat),
        .pop       (pop),
        .flush     (flush),
        .head      (head_beat),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign st_valid = !fifo_empty;
    assign st_data  = st_valid ? head_beat.data : '0;
    assign st_sop   = st_valid && head_beat.sop;
    assign st_eop   = st_valid && head_beat.eop;

    // NOTE: every state register uses <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            len_q          <= '0;
            issued         <= '0;
            cs_sop         <= 1'b0;
            cs_eop         <= 1'b0;
            inflight       <= 1'b0;
            infl_sop       <= 1'b0;
            infl_eop       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= mem_chipselect;
            infl_sop <= cs_sop;
            infl_eop <= cs_eop;
            if (flush) begin
                state          <= DONE;
                mem_chipselect <= 1'b0;
                inflight       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy        <= 1'b1;
                            len_q       <= length;
                            issued      <= '0;
                            mem_address <= base_addr;
                            if (length != '0) begin
                                state          <= READ;
                                mem_chipselect <= 1'b1;
                                cs_sop         <= 1'b1;
                                cs_eop         <= (length == ADDR_W'(1));
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    READ: begin
                        issued <= issued_next;
                        if (mem_chipselect) mem_address <= addr_inc;
                        mem_chipselect <= can_issue;
                        cs_sop         <= 1'b0;
                        cs_eop         <= (issued_next == len_q - ADDR_W'(1));
                        if (issued_next == len_q) state <= DRAIN;
                    end
                    DRAIN: begin
                        // No reads are issued here, so an empty FIFO after this edge means nothing is left.
                        if (count_next == '0) state <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef STREAM_READER_CKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cksum <= '0;
        end else if (state == IDLE && start) begin
            cksum <= '0;
        end else if (pop) begin
            cksum <= cksum + st_data;
        end
    end
`endif

endmodule

// File: tb/tb_nios_system_onchip_stream_reader.sv
// Self-checking bench: RAM slave model, packet-level reference monitor and directed/random transfers.
// Build with STREAM_READER_CKSUM_EN defined to also check the checksum port.
module tb_nios_system_onchip_stream_reader;

    localparam int MEM_WORDS  = 31250;
    localparam int ADDR_W     = 15;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] length = '0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata = '0;
    logic [31:0]       st_data;
    logic              st_valid;
    logic              st_ready = 1'b1;
    logic              st_sop;
    logic              st_eop;
`ifdef STREAM_READER_CKSUM_EN
    logic [31:0]       cksum;
`endif

    nios_system_onchip_stream_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop)
`ifdef STREAM_READER_CKSUM_EN
        ,.cksum         (cksum)
`endif
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // RAM slave: one-cycle read latency, garbage on cycles without a read.
    logic [31:0] ram [MEM_WORDS];
    always @(posedge clk) mem_readdata <= mem_chipselect ? ram[mem_address] : $urandom;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sink ready pattern: 0 = always ready, 1 = toggling, 2 = random.
    int ready_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       st_ready = 1'b1;
            1:       st_ready = ~st_ready;
            default: st_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Packet-level reference: beat k carries ram[(base+k) mod MEM_WORDS], sop on k==0, eop on k==len-1.
    int          exp_base = 0;
    int          exp_len = 0;
    int          n_issued = 0;
    int          n_beats = 0;
    int          start_cyc = 0;
    int          first_valid_cyc = -1;
    int          last_beat_cyc = -1;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] exp_sum = '0;
    logic [31:0] prev_data = '0;
    bit          stalled_prev = 1'b0;

    function automatic logic [31:0] exp_word(input int k);
        return ram[(exp_base + k) % MEM_WORDS];
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (start && !busy) begin
                exp_base        = int'(base_addr);
                exp_len         = int'(length);
                n_issued        = 0;
                n_beats         = 0;
                exp_sum         = '0;
                start_cyc       = cyc;
                first_valid_cyc = -1;
                last_beat_cyc   = -1;
            end
            if (mem_chipselect) begin
                check("issue_in_range", 32'(n_issued < exp_len), 32'd1);
                check("issue_addr", 32'(mem_address), 32'((exp_base + n_issued) % MEM_WORDS));
                check("issue_room", 32'(n_issued + 1 - n_beats <= FIFO_DEPTH), 32'd1);
                n_issued++;
            end
            if (stalled_prev) begin
                check("stall_valid", 32'(st_valid), 32'd1);
                check("stall_data", st_data, prev_data);
            end
            if (st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (st_valid && st_ready) begin
                check("beat_in_range", 32'(n_beats < exp_len), 32'd1);
                check("beat_data", st_data, exp_word(n_beats));
                check("beat_sop", 32'(st_sop), 32'(n_beats == 0));
                check("beat_eop", 32'(st_eop), 32'(n_beats == exp_len - 1));
                exp_sum       = exp_sum + st_data;
                n_beats++;
                last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            stalled_prev = st_valid && !st_ready;
            prev_data    = st_data;
        end
    end

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        @(posedge clk);
        #1;
        base_addr = base;
        length    = len;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic run_xfer(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len, input int mode);
        int d0;
        int lat;
        ready_mode = mode;
        d0 = done_cnt;
        pulse_start(base, len);
        wait_done(40 + 8 * int'(len), d0);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(done_cnt), 32'(d0 + 1));
        check("beats", 32'(n_beats), 32'(len));
        check("issues", 32'(n_issued), 32'(len));
        check("idle_busy", 32'(busy), 32'd0);
        if (len != '0) begin
            // Accepted at the start edge; issue cycle, then readdata captured at the second edge.
            check("first_valid_lat", 32'(first_valid_cyc - (start_cyc + 1)), 32'd2);
            lat = done_cyc - last_beat_cyc;
            check("done_after_last", 32'(lat >= 1 && lat <= 2), 32'd1);
            if (mode == 0) check("gap_free", 32'(last_beat_cyc - first_valid_cyc), 32'(int'(len) - 1));
        end else begin
            check("empty_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
            lat = done_cyc - (start_cyc + 1);
            check("empty_done_lat", 32'(lat >= 1 && lat <= 2), 32'd1);
        end
`ifdef STREAM_READER_CKSUM_EN
        check("cksum", cksum, exp_sum);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
        check({tag, "_addr"}, 32'(mem_address), 32'd0);
        check({tag, "_valid"}, 32'(st_valid), 32'd0);
        check({tag, "_sop"}, 32'(st_sop), 32'd0);
        check({tag, "_eop"}, 32'(st_eop), 32'd0);
`ifdef STREAM_READER_CKSUM_EN
        check({tag, "_cksum"}, cksum, 32'd0);
`endif
    endtask

    initial begin
        int d0;
        int n;
        int beats_at_abort;
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("tie_write", 32'(mem_write), 32'd0);
        check("tie_be", 32'(mem_byteenable), 32'hF);
        check("tie_clken", 32'(mem_clken), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        run_xfer(15'd0, 15'd8, 0);
        run_xfer(15'd31248, 15'd4, 0);
        run_xfer(15'($urandom_range(0, MEM_WORDS - 1)), 15'd6, 1);
        run_xfer(15'd123, 15'd0, 0);
        run_xfer(15'd31240, 15'd1, 2);
        for (int t = 0; t < 6; t++) begin
            run_xfer(15'($urandom_range(0, MEM_WORDS - 1)), 15'($urandom_range(1, 24)), 2);
        end
        run_xfer(15'd31200, 15'd90, 2);

        // Abort after ten delivered beats.
        ready_mode = 0;
        d0 = done_cnt;
        pulse_start(15'd500, 15'd100);
        n = 0;
        while (n_beats < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach10", 32'(n_beats >= 10), 32'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        beats_at_abort = n_beats;
        check("abort_cs", 32'(mem_chipselect), 32'd0);
        check("abort_valid", 32'(st_valid), 32'd0);
        wait_done(6, d0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_done_once", 32'(done_cnt), 32'(d0 + 1));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_more_beats", 32'(n_beats), 32'(beats_at_abort));
`ifdef STREAM_READER_CKSUM_EN
        check("abort_cksum", cksum, exp_sum);
`endif
        run_xfer(15'd9, 15'd5, 0);

        // Abort while idle has no effect.
        d0 = done_cnt;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_done", 32'(done_cnt), 32'(d0));

        // A second start while busy must not disturb the running transfer.
        ready_mode = 2;
        d0 = done_cnt;
        pulse_start(15'd200, 15'd12);
        repeat (4) @(posedge clk);
        #1;
        base_addr = 15'd7;
        length    = 15'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(300, d0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_start_beats", 32'(n_beats), 32'd12);
        check("busy_start_done", 32'(done_cnt), 32'(d0 + 1));

        // Asynchronous reset in the middle of a transfer.
        ready_mode = 0;
        pulse_start(15'd50, 15'd40);
        repeat (6) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        run_xfer(15'd31249, 15'd3, 1);

`ifdef STREAM_READER_CKSUM_EN
        ram[0] = 32'd1;
        ram[1] = 32'd2;
        ram[2] = 32'd3;
        run_xfer(15'd0, 15'd3, 0);
        check("cksum_123", cksum, 32'd6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
